// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer for the 64x32 guitar note RAM.
// Records OR-accumulated note vectors once per tempo tick and plays them back at the same rate.
module note_seq_ctrl #(
  parameter int ADDR_W = 6,
  parameter int NOTE_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_tick,
  input  logic              i_select,
  input  logic              i_back,
  input  logic              i_mode_play,
  input  logic [NOTE_W-1:0] i_note_in,
  input  logic [NOTE_W-1:0] i_ram_q,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_wren,
  output logic [NOTE_W-1:0] o_ram_data,
  output logic [NOTE_W-1:0] o_note_out,
  output logic              o_note_valid,
  output logic [ADDR_W:0]   o_length,
  output logic [3:0]        o_state
);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    SEL_REL      = 4'd1,
    REC_ARM      = 4'd2,
    REC_ARM_REL  = 4'd3,
    REC          = 4'd4,
    REC_STOP_REL = 4'd5,
    DONE         = 4'd6,
    PLAY         = 4'd7
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_rd_ptr;
  logic [NOTE_W-1:0]   r_capture;
  logic                r_vld_p0;
  logic                r_vld_p1;

  logic                w_last_wr;
  logic                w_rd_end;
  logic [NOTE_W-1:0]   w_word;

  // Bits 30 and above are reserved in the stored word and always written as zero.
  function automatic logic [NOTE_W-1:0] clear_reserved(input logic [NOTE_W-1:0] w);
    logic [NOTE_W-1:0] r;
    r = w;
    for (int i = 30; i < NOTE_W; i++) r[i] = 1'b0;
    return r;
  endfunction

  assign w_last_wr = (r_wr_ptr == {ADDR_W{1'b1}});
  assign w_rd_end  = (r_rd_ptr == o_length);
  assign w_word    = clear_reserved(r_capture | i_note_in);
  assign o_state   = r_state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_capture    <= '0;
      r_vld_p0     <= 1'b0;
      r_vld_p1     <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_wren   <= 1'b0;
      o_ram_data   <= '0;
      o_note_out   <= '0;
      o_note_valid <= 1'b0;
      o_length     <= '0;
    end else begin
      o_ram_addr   <= '0;
      o_ram_wren   <= 1'b0;
      o_note_valid <= 1'b0;
      r_vld_p0     <= 1'b0;
      r_vld_p1     <= r_vld_p0;
      case (r_state)
        IDLE: begin
          if (i_select) r_state <= SEL_REL;
        end
        SEL_REL: begin
          if (!i_select) begin
            if (!i_mode_play) begin
              r_state <= REC_ARM;
            end else if (o_length != '0) begin
              r_state  <= PLAY;
              r_rd_ptr <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        REC_ARM: begin
          if (i_back)        r_state <= IDLE;
          else if (i_select) r_state <= REC_ARM_REL;
        end
        REC_ARM_REL: begin
          if (!i_select) begin
            r_state   <= REC;
            r_wr_ptr  <= '0;
            o_length  <= '0;
            r_capture <= '0;
          end
        end
        REC: begin
          o_ram_addr <= r_wr_ptr;
          if (i_tick) begin
            // Registered write: address, data and enable all land the cycle after the tick.
            o_ram_wren <= 1'b1;
            o_ram_data <= w_word;
            r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
            o_length   <= o_length + (ADDR_W+1)'(1);
            r_capture  <= '0;
            if (w_last_wr)     r_state <= DONE;
            else if (i_select) r_state <= REC_STOP_REL;
          end else begin
            r_capture <= r_capture | i_note_in;
            if (i_select) r_state <= REC_STOP_REL;
          end
        end
        REC_STOP_REL: begin
          if (!i_select) r_state <= DONE;
        end
        DONE: begin
          if (i_back || i_select) r_state <= IDLE;
        end
        PLAY: begin
          o_ram_addr <= r_rd_ptr[ADDR_W-1:0];
          if (i_back || (i_tick && w_rd_end)) begin
            // Leaving playback drops any read still in flight.
            r_state    <= IDLE;
            o_note_out <= '0;
            r_vld_p0   <= 1'b0;
            r_vld_p1   <= 1'b0;
          end else begin
            if (i_tick) begin
              r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
              r_vld_p0 <= 1'b1;
            end
            // Stage p1 -> output: RAM data for the address issued two cycles ago.
            if (r_vld_p1) begin
              o_note_out   <= i_ram_q;
              o_note_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
